// File: rtl/pos_fifo.sv
// -----------------------------------------------------------------------------
// pos_fifo
//
// Single-clock synchronous FIFO (2**ADDR_WIDTH entries x DATA_WIDTH bits)
// behind one shared tri-state data lane. The bus master picks the direction
// with read_write and qualifies each transfer with enable:
//   - read_write = 1 : master drives data_io, enabled edges push into the FIFO
//   - read_write = 0 : FIFO drives data_io from its output register, enabled
//                      edges pop the next entry into that register
//
// Ports
//   clk         in   sole clock, all state changes on its rising edge
//   rst         in   synchronous, active-high reset (pointers, count, dout)
//   read_write  in   direction select: 1 = write, 0 = read
//   enable      in   transfer qualifier; all state holds while low
//   data_io     io   shared data bus, driven by the FIFO only when reading
//   full        out  high when the FIFO holds 2**ADDR_WIDTH entries
//   empty       out  high when the FIFO holds no entries
// -----------------------------------------------------------------------------
module pos_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_write,
  input  logic                  enable,
  inout  wire [DATA_WIDTH-1:0]  data_io,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // The counter is one bit wider than the pointers so that a completely
  // full FIFO (DEPTH entries) is distinguishable from an empty one.
  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage and control state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;

  logic wr_en;
  logic rd_en;

  // Flags decode straight from the registered count, so they change right
  // after the edge that changes the occupancy.
  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // Writes into a full FIFO and reads from an empty FIFO are dropped here,
  // which leaves memory, pointers, count and dout untouched.
  assign wr_en = enable &  read_write & ~full;
  assign rd_en = enable & ~read_write & ~empty;

  // The FIFO owns the lane whenever the master selects read, regardless of
  // enable or rst; the master must release the lane on the same change.
  assign data_io = read_write ? {DATA_WIDTH{1'bz}} : dout_q;

  // Next-state logic. Pointers roll over naturally from DEPTH-1 to 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
  end

  // Control state and output register. Reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Memory array is never cleared; after reset old contents are simply
  // unreachable because the count is zero. Writes are suppressed during
  // reset so that reset strictly dominates a coincident push.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= data_io;
    end
  end

endmodule

// File: tb/tb_pos_fifo.sv
module tb_pos_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       read_write;
  logic       enable;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] data_io;
  logic       full;
  logic       empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Bench side of the shared lane: drives only while writing.
  assign data_io = drv_en ? drv_val : 8'hzz;

  pos_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_write (read_write),
    .enable     (enable),
    .data_io    (data_io),
    .full       (full),
    .empty      (empty)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] v);
    read_write = 1'b1;
    drv_en     = 1'b1;
    drv_val    = v;
    enable     = 1'b1;
    tick();
  endtask

  task automatic do_read();
    drv_en     = 1'b0;
    read_write = 1'b0;
    enable     = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; read_write = 1'b0; enable = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
    tick();
    tick();
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL reset_empty actual=%b expected=1", empty);
    end
    checks++;
    if (full !== 1'b0) begin
      failures++; $display("FAIL reset_full actual=%b expected=0", full);
    end
    checks++;
    if (data_io !== 8'h00) begin
      failures++; $display("FAIL reset_data actual=%h expected=00", data_io);
    end
    rst = 1'b0;
  endtask

  task automatic test_ordering();
    logic [7:0] vals [4];
    vals[0] = 8'd122; vals[1] = 8'd0; vals[2] = 8'd2; vals[3] = 8'd4;
    for (int i = 0; i < 4; i++) begin
      do_write(vals[i]);
      if (i == 0) begin
        checks++;
        if (empty !== 1'b0) begin
          failures++; $display("FAIL order_first_write_empty actual=%b expected=0", empty);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_read();
      checks++;
      if (data_io !== vals[i]) begin
        failures++; $display("FAIL order_read%0d actual=%h expected=%h", i, data_io, vals[i]);
      end
      checks++;
      if (empty !== (i == 3)) begin
        failures++; $display("FAIL order_empty%0d actual=%b expected=%b", i, empty, (i == 3));
      end
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 1024; i++) begin
      do_write(8'(2 * i));
      if (i == 1022) begin
        checks++;
        if (full !== 1'b0) begin
          failures++; $display("FAIL fill_full_early actual=%b expected=0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1) begin
      failures++; $display("FAIL fill_full actual=%b expected=1", full);
    end
    // Overflow attempt must be ignored
    do_write(8'h55);
    checks++;
    if (full !== 1'b1) begin
      failures++; $display("FAIL overflow_full actual=%b expected=1", full);
    end
    for (int i = 0; i < 1024; i++) begin
      do_read();
      checks++;
      if (data_io !== 8'(2 * i)) begin
        failures++; $display("FAIL drain_data%0d actual=%h expected=%h", i, data_io, 8'(2 * i));
      end
      if (i == 0) begin
        checks++;
        if (full !== 1'b0) begin
          failures++; $display("FAIL drain_first_full actual=%b expected=0", full);
        end
      end
      if (i == 1022) begin
        checks++;
        if (empty !== 1'b0) begin
          failures++; $display("FAIL drain_empty_early actual=%b expected=0", empty);
        end
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL drain_empty actual=%b expected=1", empty);
    end
    for (int i = 0; i < 2; i++) begin
      do_read();
      checks++;
      if (data_io !== 8'hFE) begin
        failures++; $display("FAIL underflow_data%0d actual=%h expected=fe", i, data_io);
      end
      checks++;
      if (empty !== 1'b1) begin
        failures++; $display("FAIL underflow_empty%0d actual=%b expected=1", i, empty);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 1000; i++) begin
      do_write(8'(i * 3 + 7));
      checks++;
      if ({full, empty} !== 2'b00) begin
        failures++; $display("FAIL wrapA_wflags%0d actual=%b expected=00", i, {full, empty});
      end
    end
    for (int i = 0; i < 1000; i++) begin
      do_read();
      checks++;
      if (data_io !== 8'(i * 3 + 7)) begin
        failures++; $display("FAIL wrapA_data%0d actual=%h expected=%h", i, data_io, 8'(i * 3 + 7));
      end
      checks++;
      if ({full, empty} !== ((i == 999) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL wrapA_rflags%0d actual=%b", i, {full, empty});
      end
    end
    // Pointers now sit at 1000, so these 100 entries cross the roll-over
    for (int i = 0; i < 100; i++) begin
      do_write(8'(i * 5 + 1));
      checks++;
      if ({full, empty} !== 2'b00) begin
        failures++; $display("FAIL wrapB_wflags%0d actual=%b expected=00", i, {full, empty});
      end
    end
    for (int i = 0; i < 100; i++) begin
      do_read();
      checks++;
      if (data_io !== 8'(i * 5 + 1)) begin
        failures++; $display("FAIL wrapB_data%0d actual=%h expected=%h", i, data_io, 8'(i * 5 + 1));
      end
      checks++;
      if ({full, empty} !== ((i == 99) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL wrapB_rflags%0d actual=%b", i, {full, empty});
      end
    end
  endtask

  task automatic test_qualifier_reset();
    // Last popped value from the wrap test: (99*5+1) mod 256 = 0xF0
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      read_write = i[0];
      drv_en     = i[0];
      drv_val    = 8'hA5;
      tick();
      checks++;
      if ({full, empty} !== 2'b01) begin
        failures++; $display("FAIL qual_flags%0d actual=%b expected=01", i, {full, empty});
      end
      if (i[0] == 1'b0) begin
        checks++;
        if (data_io !== 8'hF0) begin
          failures++; $display("FAIL qual_dout%0d actual=%h expected=f0", i, data_io);
        end
      end
    end
    for (int i = 0; i < 5; i++) do_write(8'(8'h30 + i));
    checks++;
    if (empty !== 1'b0) begin
      failures++; $display("FAIL mid_fill_empty actual=%b expected=0", empty);
    end
    // Reset with a write request present: reset must dominate
    rst = 1'b1; read_write = 1'b1; enable = 1'b1; drv_en = 1'b1; drv_val = 8'h77;
    tick();
    rst = 1'b0;
    checks++;
    if ({full, empty} !== 2'b01) begin
      failures++; $display("FAIL midrst_flags actual=%b expected=01", {full, empty});
    end
    do_read();
    checks++;
    if (data_io !== 8'h00) begin
      failures++; $display("FAIL midrst_read_data actual=%h expected=00", data_io);
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL midrst_read_empty actual=%b expected=1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_fill_drain();
    test_wrap();
    test_qualifier_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
